// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the byte-serial memory arbiter.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RD,
    WR
  } state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

  localparam logic [2:0] LEN_B = 3'd1;
  localparam logic [2:0] LEN_H = 3'd2;
  localparam logic [2:0] LEN_W = 3'd4;

  localparam logic [1:0] IO_SEL_DEF = 2'b11;

  function automatic logic is_io(logic [1:0] region, logic [1:0] sel);
    return region == sel;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Request/response ports of the fetch and data requesters plus the byte-wide memory pins.
interface mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_done;
  logic [31:0] if_data;
  logic        d_req;
  logic        d_we;
  logic [2:0]  d_len;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_done;
  logic [31:0] d_rdata;
  logic [1:0]  busy;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_len, d_addr, d_wdata, mem_din,
    output if_done, if_data, d_done, d_rdata, busy, mem_dout, mem_a, mem_wr
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_len, d_addr, d_wdata, mem_din,
    input  if_done, if_data, d_done, d_rdata, busy, mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_byte_seq.sv
// Byte counter, address offset and byte-lane mux/demux for a single granted access.
module mem_byte_seq (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clear_i,
  input  logic        step_i,
  input  logic        cap_i,
  input  logic        hold_prev_i,
  input  logic [31:0] base_i,
  input  logic [31:0] wdata_i,
  input  logic [7:0]  din_i,
  output logic [2:0]  cnt_o,
  output logic [31:0] addr_o,
  output logic [7:0]  dout_o,
  output logic [31:0] word_o
);

  logic [2:0]  cnt_q, cnt_d, prev;
  logic [31:0] buf_q, buf_d;

  assign prev = cnt_q - 3'd1;

  always_comb begin
    cnt_d = cnt_q;
    buf_d = buf_q;
    if (clear_i) begin
      cnt_d = '0;
      buf_d = '0;
    end else begin
      if (step_i) cnt_d = cnt_q + 3'd1;
      if (cap_i)  buf_d[{prev[1:0], 3'b000} +: 8] = din_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      buf_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      buf_q <= buf_d;
    end
  end

  // Re-driving the previous address keeps mem_din aligned with the byte still owed.
  assign cnt_o  = cnt_q;
  assign addr_o = base_i + {29'd0, (hold_prev_i ? prev : cnt_q)};
  assign dout_o = wdata_i[{cnt_q[1:0], 3'b000} +: 8];

  always_comb begin
    word_o = buf_q;
    if (cnt_q != '0) word_o[{prev[1:0], 3'b000} +: 8] = din_i;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates fetch vs. data onto the byte-wide memory bus, assembling words little-endian.
// Define MEM_ARBITER_ABORT_EN to let flush_in abort an in-flight fetch.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter logic [1:0] IO_SEL    = IO_SEL_DEF,
  parameter bit         DATA_PRIO = 1'b1
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         rdy_in,
  input  logic         flush_in,
  input  logic         io_buffer_full,
  mem_arbiter_if.slave bus
);

  state_e      state_q, state_d;
  owner_e      owner_q, owner_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic [2:0]  len_q, len_d;

  logic [2:0]  cnt;
  logic [31:0] seq_addr, word;
  logic [7:0]  seq_dout;
  logic        flush_fetch, if_ok, pick_d, pick_if, abort, io_wait;
  logic        rd_last, wr_last, rd_go, wr_go, rd_done;

`ifdef MEM_ARBITER_ABORT_EN
  assign flush_fetch = flush_in;
`else
  logic unused_flush;
  assign unused_flush = flush_in;
  assign flush_fetch  = 1'b0;
`endif

  assign if_ok   = bus.if_req && !flush_fetch;
  assign pick_d  = bus.d_req && (DATA_PRIO || !if_ok);
  assign pick_if = if_ok && !pick_d;
  assign abort   = flush_fetch && (state_q == RD) && (owner_q == OWN_IF);
  assign io_wait = is_io(addr_q[17:16], IO_SEL) && io_buffer_full;
  assign rd_last = (cnt == len_q);
  assign wr_last = (cnt == len_q - 3'd1);
  assign rd_go   = (state_q == RD) && rdy_in && !abort;
  assign wr_go   = (state_q == WR) && rdy_in && !io_wait;
  assign rd_done = rd_go && rd_last;

  mem_byte_seq u_seq (
    .clk_i       (clk_in),
    .rst_i       (rst_in),
    .clear_i     (state_d == IDLE),
    .step_i      ((rd_go && !rd_last) || (wr_go && !wr_last)),
    .cap_i       (rd_go && (cnt != '0)),
    .hold_prev_i ((state_q == RD) && (cnt != '0) && (!rdy_in || rd_last)),
    .base_i      (addr_q),
    .wdata_i     (wdata_q),
    .din_i       (bus.mem_din),
    .cnt_o       (cnt),
    .addr_o      (seq_addr),
    .dout_o      (seq_dout),
    .word_o      (word)
  );

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      addr_q  <= '0;
      len_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    addr_d  = addr_q;
    len_d   = len_q;
    wdata_d = wdata_q;
    case (state_q)
      IDLE: begin
        if (rdy_in && pick_d) begin
          state_d = bus.d_we ? WR : RD;
          owner_d = OWN_D;
          addr_d  = bus.d_addr;
          len_d   = bus.d_len;
          wdata_d = bus.d_wdata;
        end else if (rdy_in && pick_if) begin
          state_d = RD;
          owner_d = OWN_IF;
          addr_d  = bus.if_addr;
          len_d   = LEN_W;
          wdata_d = '0;
        end
      end
      RD:      if (rdy_in && (abort || rd_last)) state_d = IDLE;
      WR:      if (wr_go && wr_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_a    = '0;
    bus.mem_wr   = 1'b0;
    bus.mem_dout = '0;
    if (state_q == RD) begin
      bus.mem_a = seq_addr;
    end else if (state_q == WR) begin
      bus.mem_a    = seq_addr;
      bus.mem_wr   = wr_go;
      bus.mem_dout = seq_dout;
    end
    bus.if_done = rd_done && (owner_q == OWN_IF);
    bus.d_done  = (rd_done && (owner_q == OWN_D)) || (wr_go && wr_last);
    bus.if_data = bus.if_done ? word : '0;
    bus.d_rdata = (rd_done && (owner_q == OWN_D)) ? word : '0;
    bus.busy    = {(state_q != IDLE) && (owner_q == OWN_D),
                   (state_q != IDLE) && (owner_q == OWN_IF)};
  end

endmodule
